instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter N, default 16, meaning instruction memory depth in 16-bit words.
REQ-002 SHALL have parameter AW, default 16, meaning the write address width in bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, level request to begin a load.
REQ-006 SHALL have port rx_data, input, 8, incoming byte.
REQ-007 SHALL have port rx_valid, input, 1, rx_data is valid.
REQ-008 SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en, output, 1, one-cycle memory write strobe.
REQ-010 SHALL have port wr_addr, output, AW, byte address of the write (always even).
REQ-011 SHALL have port wr_data, output, 16, instruction word.
REQ-012 SHALL have port busy, output, 1, load in progress (CPU stall).
REQ-013 SHALL have port done, output, 1, load complete (sticky).
REQ-014 SHALL have port overflow, output, 1, sticky: image exceeded N words.
REQ-015 SHALL have port chk_err, output, 1, sticky checksum mismatch.

Function
REQ-016 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK and DONE.
REQ-017 SHALL accept a byte only on the cycle where rx_valid and rx_ready are both high.
REQ-018 SHALL drive rx_ready high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
REQ-019 SHALL move IDLE->LEN_HI when start=1, and move DONE->LEN_HI when start=1, clearing done, overflow and chk_err in the same cycle.
REQ-020 SHALL ignore start in every other state.
REQ-021 SHALL treat the first two accepted bytes as a 16-bit word count, big-endian (high byte first).
REQ-022 SHALL, after LEN_LO, go to CHK/DONE if the count is 0, otherwise to DATA_HI.
REQ-023 SHALL capture the high byte in DATA_HI and the low byte in DATA_LO, then enter WRITE.
REQ-024 SHALL, in WRITE: pulse wr_en for exactly 1 cycle; set wr_addr = 2*idx; set wr_data = {hi,lo}; increment idx; decrement the remaining count.
REQ-025 SHALL give a latency of 1 cycle from accepting the low byte to the wr_en pulse.
REQ-026 SHALL, from WRITE, go to DATA_HI if remaining != 0, otherwise to CHK (macro defined) or DONE.
REQ-027 SHALL, when idx >= N, suppress wr_en, set overflow, and still consume the bytes so the stream stays aligned.
REQ-028 SHALL compute wr_addr modulo 2^AW, with no other wrap handling.
REQ-029 SHALL drive busy = 1 in every state except IDLE and DONE.
REQ-030 SHALL hold done = 1 while in DONE.
REQ-031 SHALL hold wr_addr and wr_data at their last written values when wr_en = 0.
REQ-032 SHALL stall the FSM on rx_valid = 0 with no timeout.

Reset
REQ-033 SHALL, on rst = 0 in any state including mid-load, force IDLE and clear all outputs, idx, the count and the checksum.
REQ-034 SHALL clear wr_en, wr_addr, wr_data, busy, done, overflow, chk_err and rx_ready to 0 on reset.
REQ-035 SHALL leave memory words already written untouched by reset.

Configuration
REQ-036 SHALL use macro INSTR_LOADER_CHECKSUM_EN.
REQ-037 SHALL, with the macro defined: XOR-accumulate every data byte (length bytes excluded); accept one trailing byte in CHK; set chk_err if that byte differs from the accumulator; then go to DONE.
REQ-038 SHALL, with the macro undefined: omit the CHK state and the accumulator, and tie chk_err to 0.
REQ-039 SHALL NOT roll back writes on a checksum error.

Structure
REQ-040 SHALL place the state enum, the byte width (8) and the length width (16) in shared package instr_loader_pkg.
REQ-041 SHALL implement the checksum as sub-module loader_checksum (clear, byte strobe, 8-bit XOR accumulator), instantiated only under the macro.

Verification
REQ-042 SHALL cover: stream 00 04 10 10 60 02 D0 04 10 11, no gaps -> writes (0,1010), (2,6002), (4,D004), (6,1011), then done = 1, overflow = 0.
REQ-043 SHALL cover: the same stream with rx_valid low 3 cycles between each byte -> identical writes, busy held throughout, rx_ready only in accept states.
REQ-044 SHALL cover: count 00 00 -> no wr_en, done asserted within 2 cycles of the second byte (plus the CHK byte if enabled).
REQ-045 SHALL cover: N = 4, count 00 05, five words -> 4 writes at 0..6, the fifth suppressed, overflow = 1, done = 1.
REQ-046 SHALL cover: rst pulsed low after 3 data bytes -> IDLE, all outputs 0; a fresh start plus full stream loads correctly.
REQ-047 SHALL cover, with the macro defined: the REQ-042 stream plus checksum B7 -> chk_err = 0; the same stream plus B6 -> chk_err = 1, and all 4 writes still occur.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and widths for the instruction loader.
// Holds the FSM state encoding and the byte, length and instruction-word widths.
package instr_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        CHK     = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/instr_loader_checksum.sv
// XOR accumulator over the image data bytes, used to check the trailing checksum.
// Present only when INSTR_LOADER_CHECKSUM_EN is defined.
// Ports: clk, rst (async active-low), clear (zero the accumulator),
//        strobe (fold data in this cycle), data (byte), acc (running XOR).
`ifdef INSTR_LOADER_CHECKSUM_EN
module loader_checksum
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (strobe) begin
            acc <= acc ^ data;
        end
    end

endmodule
`endif

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: receives a big-endian 16-bit word count followed
// by that many big-endian instruction words and writes them to instruction memory
// at byte addresses 0, 2, 4, ... Words beyond depth N are consumed but not written.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
// Ports: clk, rst (async active-low), start (level request),
//        rx_data/rx_valid/rx_ready (byte stream handshake),
//        wr_en/wr_addr/wr_data (memory write port),
//        busy, done, overflow, chk_err (status; done/overflow/chk_err sticky).
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              chk_err
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  idx;
    logic [BYTE_W-1:0] hi_byte;
    logic              accept_c;
    logic              start_c;
    logic              in_range_c;

    assign accept_c   = rx_valid && rx_ready;
    assign start_c    = start && ((state == IDLE) || (state == DONE));
    assign in_range_c = 32'(idx) < N;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LEN_HI;
            LEN_HI:  if (accept_c) state_nx = LEN_LO;
            LEN_LO: begin
                if (accept_c) begin
                    if ({remaining[LEN_W-1:BYTE_W], rx_data} == '0) state_nx = END_STATE;
                    else                                           state_nx = DATA_HI;
                end
            end
            DATA_HI: if (accept_c) state_nx = DATA_LO;
            DATA_LO: if (accept_c) state_nx = WRITE;
            // remaining is decremented on leaving WRITE, so one left means last word
            WRITE:   state_nx = (remaining != LEN_W'(1)) ? DATA_HI : END_STATE;
            CHK:     if (accept_c) state_nx = DONE;
            DONE:    if (start) state_nx = LEN_HI;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_ready <= (state_nx == LEN_HI) || (state_nx == LEN_LO) || (state_nx == DATA_HI)
                     || (state_nx == DATA_LO) || (state_nx == CHK);
            busy     <= (state_nx != IDLE) && (state_nx != DONE);
            done     <= (state_nx == DONE);
        end
    end

    // Length capture, word assembly and memory write; the write strobe is raised as
    // the low byte is accepted so it is visible during the WRITE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            idx       <= '0;
            hi_byte   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_c) begin
                remaining <= '0;
                idx       <= '0;
                overflow  <= 1'b0;
            end else begin
                case (state)
                    LEN_HI:  if (accept_c) remaining[LEN_W-1:BYTE_W] <= rx_data;
                    LEN_LO:  if (accept_c) remaining[BYTE_W-1:0] <= rx_data;
                    DATA_HI: if (accept_c) hi_byte <= rx_data;
                    DATA_LO: begin
                        if (accept_c) begin
                            if (in_range_c) begin
                                wr_en   <= 1'b1;
                                wr_addr <= AW'({idx, 1'b0});
                                wr_data <= {hi_byte, rx_data};
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        idx       <= idx + LEN_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_acc;

    loader_checksum u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_c),
        .strobe (accept_c && ((state == DATA_HI) || (state == DATA_LO))),
        .data   (rx_data),
        .acc    (chk_acc)
    );

    // Compare the trailing byte against the accumulated XOR of all data bytes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_err <= 1'b0;
        end else if (start_c) begin
            chk_err <= 1'b0;
        end else if ((state == CHK) && accept_c && (rx_data != chk_acc)) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (N = 4 to reach the overflow boundary).
module tb_instr_loader;

    localparam int unsigned N_TB  = 4;
    localparam int unsigned AW_TB = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              wr_en;
    logic [AW_TB-1:0]  wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              chk_err;

    int tests = 0;
    int fails = 0;
    int busy_bad = 0;
    int rr_bad = 0;

    logic [15:0] got_a[$];
    logic [15:0] got_d[$];

    instr_loader #(.N(N_TB), .AW(AW_TB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .chk_err  (chk_err)
    );

    always #5 clk = ~clk;

    // Write capture and handshake sanity, sampled mid-cycle
    always @(negedge clk) begin
        if (rst && wr_en) begin
            got_a.push_back(wr_addr);
            got_d.push_back(wr_data);
        end
        if (rst && rx_ready && (wr_en || !busy)) rr_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one byte after gap idle cycles and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            if (!busy) busy_bad++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL rx_ready timeout: got 0 expected 1");
        end else begin
            if (!busy) busy_bad++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] cnt, input logic [15:0] words[$], input int gap,
                           input bit bad_chk, input string tag);
        logic [15:0] exp_a[$];
        logic [15:0] exp_d[$];
        logic [15:0] w;
        logic [7:0]  x;
        logic [7:0]  cb;
        int          n;
        int          to;
        n = int'(cnt);
        x = 8'h00;
        got_a.delete();
        got_d.delete();
        busy_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i < int'(N_TB)) begin
                exp_a.push_back(16'(2 * i));
                exp_d.push_back(words[i]);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " done_cleared"}, 32'(done), 32'd0);
        check({tag, " overflow_cleared"}, 32'(overflow), 32'd0);
        send_byte(cnt[15:8], gap);
        send_byte(cnt[7:0], gap);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            x = x ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], gap);
            send_byte(w[7:0], gap);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        cb = bad_chk ? (x ^ 8'h01) : x;
        send_byte(cb, gap);
`else
        cb = x;
`endif
        to = 0;
        while (!done && to < 3) begin
            @(negedge clk);
            to++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " overflow"}, 32'(overflow), 32'((n > int'(N_TB)) ? 1 : 0));
`ifdef INSTR_LOADER_CHECKSUM_EN
        check({tag, " chk_err"}, 32'(chk_err), 32'(bad_chk));
`else
        check({tag, " chk_err"}, 32'(chk_err), 32'd0);
`endif
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " busy_held"}, 32'(busy_bad), 32'd0);
        check({tag, " n_writes"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check({tag, " wr_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
            check({tag, " wr_data"}, 32'(got_d[i]), 32'(exp_d[i]));
        end
        if (exp_a.size() > 0) begin
            check({tag, " addr_hold"}, 32'(wr_addr), 32'(exp_a[exp_a.size() - 1]));
            check({tag, " data_hold"}, 32'(wr_data), 32'(exp_d[exp_d.size() - 1]));
        end
        if (cb == 8'hFF) x = 8'h00;
    endtask

    typedef struct {
        logic [15:0] cnt;
        int          gap;
        int          exp_writes;
        bit          exp_ovf;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] base[$];
    logic [15:0] rw[$];

    initial begin
        tbl[0] = '{16'd4, 0, 4, 1'b0};
        tbl[1] = '{16'd4, 3, 4, 1'b0};
        tbl[2] = '{16'd0, 0, 0, 1'b0};
        tbl[3] = '{16'd5, 0, 4, 1'b1};
        tbl[4] = '{16'd1, 1, 1, 1'b0};
        tbl[5] = '{16'd3, 2, 3, 1'b0};
        base = '{16'h1010, 16'h6002, 16'hD004, 16'h1011, 16'hABCD, 16'h5A5A, 16'h0001, 16'hFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst rx_ready", 32'(rx_ready), 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst wr_addr", 32'(wr_addr), 32'd0);
        check("rst wr_data", 32'(wr_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst chk_err", 32'(chk_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven loads
        for (int t = 0; t < 6; t++) begin
            do_load(tbl[t].cnt, base, tbl[t].gap, 1'b0, $sformatf("vec%0d", t));
            check($sformatf("vec%0d tbl_writes", t), 32'(got_a.size()), 32'(tbl[t].exp_writes));
            check($sformatf("vec%0d tbl_ovf", t), 32'(overflow), 32'(tbl[t].exp_ovf));
            repeat (2) @(negedge clk);
        end

        // Start is ignored mid-load; rst low after three data bytes aborts the load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        start = 1'b1;
        send_byte(8'h10, 0);
        start = 1'b0;
        send_byte(8'h10, 0);
        send_byte(8'h60, 0);
        rst = 1'b0;
        #1;
        check("midrst rx_ready", 32'(rx_ready), 32'd0);
        check("midrst wr_en", 32'(wr_en), 32'd0);
        check("midrst wr_addr", 32'(wr_addr), 32'd0);
        check("midrst wr_data", 32'(wr_data), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst stays idle", 32'(busy), 32'd0);
        do_load(16'd4, base, 0, 1'b0, "after_rst");

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Corrupted checksum: writes still happen, chk_err raised
        do_load(16'd4, base, 0, 1'b1, "bad_chk");
        do_load(16'd4, base, 1, 1'b0, "good_chk");
`endif

        // Randomized loads against the model inside do_load
        for (int r = 0; r < 12; r++) begin
            rw.delete();
            for (int k = 0; k < 8; k++) rw.push_back(16'($urandom));
            do_load(16'($urandom_range(0, 7)), rw, int'($urandom_range(0, 2)),
                    bit'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        check("rx_ready only while busy and not writing", 32'(rr_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
